div_seq: RTL and testbench

DIV_SEQ -- requirements
Module: div_seq

---
 rtl/div_seq.sv | 122 ++++++++++++
 tb/tb_div_seq.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// Sequential RV32M divider (DIV/DIVU/REM/REMU), one restoring shift-subtract step per cycle.
// Latency XLEN+1 cycles (1 for divide-by-zero/overflow); stall holds the issuing stage, start ignored while busy, flush aborts.
module div_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] ONE     = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_rem_op, r_neg_q, r_neg_r;
  logic [XLEN-1:0] r_quot, r_rem, r_div, r_result;
  logic [CW-1:0]   r_cnt;

  logic            w_signed, w_sign_a, w_sign_b, w_b_zero, w_ovf, w_accept;
  logic [XLEN-1:0] w_abs_a, w_abs_b;
  logic [XLEN:0]   w_shift, w_diff;
  logic            w_ge;
  logic [XLEN-1:0] w_step_rem, w_step_quot, w_q_out, w_r_out, w_final;

  assign w_signed = ~func3[0];
  assign w_sign_a = w_signed & op_a[XLEN-1];
  assign w_sign_b = w_signed & op_b[XLEN-1];
  assign w_abs_a  = w_sign_a ? (~op_a + ONE) : op_a;
  assign w_abs_b  = w_sign_b ? (~op_b + ONE) : op_b;
  assign w_b_zero = (op_b == '0);
  assign w_ovf    = w_signed & (op_a == MIN_NEG) & (op_b == '1);
  // Gated by rst_n so stall stays low while reset is held, even with start asserted.
  assign w_accept = rst_n & start & func3[2] & ~flush & (r_state == S_IDLE);

  // Remainder stays below the divisor, so bit XLEN of the difference is the borrow.
  assign w_shift     = {r_rem, r_quot[XLEN-1]};
  assign w_diff      = w_shift - {1'b0, r_div};
  assign w_ge        = ~w_diff[XLEN];
  assign w_step_rem  = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
  assign w_step_quot = {r_quot[XLEN-2:0], w_ge};

  assign w_q_out = r_neg_q ? (~r_quot + ONE) : r_quot;
  assign w_r_out = r_neg_r ? (~r_rem + ONE) : r_rem;
  assign w_final = r_rem_op ? w_r_out : w_q_out;

  always_comb begin
    w_state_nxt = r_state;
    done        = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = (w_b_zero || w_ovf) ? S_DONE : S_CALC;
      S_CALC: if (r_cnt == CW'(1)) w_state_nxt = S_DONE;
      S_DONE: begin
        done        = ~flush;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) w_state_nxt = S_IDLE;
  end

  assign busy   = (r_state != S_IDLE);
  assign stall  = busy | w_accept;
  assign result = done ? w_final : r_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem_op <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_quot   <= '0;
      r_rem    <= '0;
      r_div    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_rem_op <= func3[1];
        r_div    <= w_abs_b;
        r_cnt    <= CW'(XLEN);
        // Shortcut cases load final values directly and bypass sign correction.
        if (w_b_zero) begin
          r_quot  <= '1;
          r_rem   <= op_a;
          r_neg_q <= 1'b0;
          r_neg_r <= 1'b0;
        end else if (w_ovf) begin
          r_quot  <= op_a;
          r_rem   <= '0;
          r_neg_q <= 1'b0;
          r_neg_r <= 1'b0;
        end else begin
          r_quot  <= w_abs_a;
          r_rem   <= '0;
          r_neg_q <= w_sign_a ^ w_sign_b;
          r_neg_r <= w_sign_a;
        end
      end else if (r_state == S_CALC && !flush) begin
        r_quot <= w_step_quot;
        r_rem  <= w_step_rem;
        r_cnt  <= r_cnt - CW'(1);
      end
      if (done) r_result <= w_final;
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: vector table plus random ops through a result scoreboard,
// with hand sequences for flush, reset mid-operation and start while busy.
module tb_div_seq;

  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  logic        clk, rst_n, start, flush, busy, stall, done;
  logic [2:0]  func3;
  logic [31:0] op_a, op_b, result;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  vec_t        vecs[18];
  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_res = '0;

  div_seq #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .func3(func3), .op_a(op_a), .op_b(op_b),
    .flush(flush), .busy(busy), .stall(stall), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      F_DIVU:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      F_REMU:  return (b == 0) ? a : a % b;
      F_DIV:   return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      default: return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
    endcase
  endfunction

  // Drives one op; poke_at>0 pulses a conflicting start during that CALC cycle.
  task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat, input int poke_at);
    int   lat;
    exp_t e;
    @(negedge clk);
    start = 1'b1; func3 = f3; op_a = a; op_b = b;
    sb.push_back('{res: exp, lat: exp_lat});
    #1 chk({nm, " stall_on_accept"}, 32'(stall), 32'd1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) start = 1'b0;
      if (poke_at > 0 && lat == poke_at) begin
        start = 1'b1; func3 = F_REMU; op_a = 32'd9; op_b = 32'd4;
      end else if (poke_at > 0 && lat == poke_at + 1) begin
        start = 1'b0;
      end
    end while (!done && lat < 60);
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL %s timeout: done not seen within %0d cycles, required at %0d", nm, lat, exp_lat);
      void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    chk({nm, " latency"}, 32'(lat), 32'(e.lat));
    chk({nm, " result"}, result, e.res);
    chk({nm, " busy_in_done"}, 32'(busy), 32'd1);
    @(negedge clk);
    chk({nm, " result_hold"}, result, e.res);
    chk({nm, " done_pulse"}, 32'(done), 32'd0);
    last_res = e.res;
  endtask

  initial begin
    int lat;
    int pulses;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; func3 = F_DIVU; op_a = '0; op_b = '0;

    vecs[0]  = '{F_DIVU, 32'd100,        32'd7,          32'd14,         33};
    vecs[1]  = '{F_REMU, 32'd100,        32'd7,          32'd2,          33};
    vecs[2]  = '{F_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33};
    vecs[3]  = '{F_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33};
    vecs[4]  = '{F_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    vecs[5]  = '{F_REMU, 32'd5,          32'd0,          32'd5,          1};
    vecs[6]  = '{F_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
    vecs[7]  = '{F_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
    vecs[8]  = '{F_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33};
    vecs[9]  = '{F_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          33};
    vecs[10] = '{F_DIV,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  1};
    vecs[11] = '{F_REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1};
    vecs[12] = '{F_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33};
    vecs[13] = '{F_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  33};
    vecs[14] = '{F_DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         33};
    vecs[15] = '{F_REM,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  33};
    vecs[16] = '{F_DIV,  32'h8000_0000,  32'd1,          32'h8000_0000,  33};
    vecs[17] = '{F_REM,  32'h8000_0000,  32'd3,          32'hFFFF_FFFE,  33};

    #2;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst result", result, 32'd0);
    start = 1'b1;
    #1 chk("rst stall_with_start", 32'(stall), 32'd0);
    start = 1'b0;
    #20;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst busy", 32'(busy), 32'd0);
    chk("post_rst stall", 32'(stall), 32'd0);
    chk("post_rst result", result, 32'd0);

    for (int i = 0; i < 18; i++)
      run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 0);

    for (int i = 0; i < 10; i++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      int          sel;
      sel = $urandom_range(0, 3);
      f3  = {1'b1, sel[1:0]};
      a   = $urandom;
      b   = (i % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
      run_op($sformatf("rnd%0d", i), f3, a, b, model(f3, a, b), 33, 0);
    end

    // Start while busy is ignored.
    run_op("busy_start", F_DIVU, 32'd100, 32'd7, 32'd14, 33, 3);

    // Flush at CALC cycle 10.
    @(negedge clk);
    start = 1'b1; func3 = F_DIVU; op_a = 32'd1000; op_b = 32'd3;
    pulses = 0;
    for (lat = 1; lat <= 10; lat++) begin
      @(negedge clk);
      if (lat == 1) start = 1'b0;
      if (done) pulses++;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush busy", 32'(busy), 32'd0);
    chk("flush done", 32'(done), 32'd0);
    chk("flush result_kept", result, last_res);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("flush no_done_pulses", 32'(pulses), 32'd0);

    // Flush wins over start in the same cycle.
    start = 1'b1; flush = 1'b1; func3 = F_DIVU;
    #1 chk("flush_vs_start stall", 32'(stall), 32'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_vs_start busy", 32'(busy), 32'd0);
    run_op("after_flush", F_DIVU, 32'd1000, 32'd3, 32'd333, 33, 0);

    // Reset at CALC cycle 5.
    @(negedge clk);
    start = 1'b1; func3 = F_DIVU; op_a = 32'd50; op_b = 32'd5;
    for (lat = 1; lat <= 5; lat++) begin
      @(negedge clk);
      if (lat == 1) start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst stall", 32'(stall), 32'd0);
    chk("midrst result", result, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("midrst no_done_pulses", 32'(pulses), 32'd0);
    chk("midrst result_after", result, 32'd0);
    run_op("after_rst", F_REMU, 32'd50, 32'd7, 32'd1, 33, 0);

    chk("scoreboard empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
